dr_tp_rx: RTL and testbench

//  Clocked receiver for a two-phase (TP) dual-rail link.
//  - Sits at the far end of an async datapath's output link: inputs out[WIDTH-1:0][1:0], returns ack_i.
//  - Detects word completion, decodes to binary, hands the word to synchronous logic over valid/ready,
//    and toggles the link acknowledge.

---
 rtl/dr_pkg.sv | 34 +++
 rtl/dr_sync.sv | 26 ++
 rtl/dr_tp_rx.sv | 115 +++++++++++
 tb/tb_dr_tp_rx.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dr_pkg.sv
// Shared dual-rail definitions: rail indices, per-bit rail type and two-phase
// decode helpers used by the receiver.
package dr_pkg;

    localparam int RAIL_NUM = 2;
    localparam int RAIL_0   = 0;
    localparam int RAIL_1   = 1;

    typedef logic [RAIL_NUM-1:0] dr_bit_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rx_state_e;

    // A bit is done once either rail differs from its reference phase.
    function automatic logic tp_done(dr_bit_t cur, dr_bit_t ref_r);
        return |(cur ^ ref_r);
    endfunction

    // Decoded value: a toggle on rail[1] means '1'.
    function automatic logic tp_val(dr_bit_t cur, dr_bit_t ref_r);
        dr_bit_t d;
        d = cur ^ ref_r;
        return d[RAIL_1];
    endfunction

    function automatic logic tp_bad(dr_bit_t cur, dr_bit_t ref_r);
        dr_bit_t d;
        d = cur ^ ref_r;
        return d[RAIL_0] & d[RAIL_1];
    endfunction

endpackage

// File: rtl/dr_sync.sv
// Two-flop synchronizer bank for asynchronous rail inputs.
module dr_sync #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o
);

    logic [N-1:0] s1_q;
    logic [N-1:0] s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/dr_tp_rx.sv
// Two-phase dual-rail link receiver: synchronizes the rails, detects word
// completion, decodes into a valid/ready output slot and toggles the link ack.
module dr_tp_rx
    import dr_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [WIDTH-1:0][RAIL_NUM-1:0] in,
    output logic                           ack_o,
    output logic [WIDTH-1:0]               data_o,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic                           err_o,
    output logic [CNT_W-1:0]               cnt_o
);

    logic [WIDTH-1:0][RAIL_NUM-1:0] s2;
    logic [WIDTH-1:0][RAIL_NUM-1:0] ref_q, ref_d;
    logic [WIDTH-1:0]               done;
    logic [WIDTH-1:0]               val;
    logic [WIDTH-1:0]               bad;
    logic                           complete;
    logic                           any_bad;
    logic                           capture;

    logic [WIDTH-1:0] data_q, data_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    rx_state_e state_q, state_d;

    dr_sync #(
        .N(WIDTH * RAIL_NUM)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (in),
        .q_o (s2)
    );

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign done[gi] = tp_done(s2[gi], ref_q[gi]);
            assign val[gi]  = tp_val(s2[gi], ref_q[gi]);
            assign bad[gi]  = tp_bad(s2[gi], ref_q[gi]);
        end
    endgenerate

    assign complete = &done;
    assign any_bad  = |bad;
    // A word may be taken while the slot is being drained in the same cycle.
    assign capture  = complete && (!valid_o || ready_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (capture) state_d = ST_FULL;
            ST_FULL:  if (!capture && ready_i) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        valid_o = (state_q == ST_FULL);
    end

    always_comb begin
        ref_d  = ref_q;
        data_d = data_q;
        ack_d  = ack_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        if (capture) begin
            ref_d  = s2;
            data_d = val;
            ack_d  = ~ack_q;
            cnt_d  = cnt_q + CNT_W'(1);
            err_d  = err_q | any_bad;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_q  <= '0;
            data_q <= '0;
            ack_q  <= 1'b0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            ref_q  <= ref_d;
            data_q <= data_d;
            ack_q  <= ack_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign ack_o  = ack_q;
    assign data_o = data_q;
    assign err_o  = err_q;
    assign cnt_o  = cnt_q;

endmodule

// File: tb/tb_dr_tp_rx.sv
// Randomized self-checking bench for dr_tp_rx driven by a two-phase sender model.
module tb_dr_tp_rx;

    logic            clk = 1'b0;
    logic            rst;
    logic [31:0][1:0] tx_rails;
    logic            ready;
    logic            ack;
    logic [31:0]     data;
    logic            valid;
    logic            err;
    logic [15:0]     cnt;

    // Narrow instance with a 4-bit counter to reach the wrap point cheaply.
    logic [7:0][1:0] tx_s;
    logic            ready_s;
    logic            ack_s;
    logic [7:0]      data_s;
    logic            valid_s;
    logic            err_s;
    logic [3:0]      cnt_s;

    int checks = 0;
    int errors = 0;

    logic        exp_ack;
    logic [15:0] exp_cnt;
    logic        exp_err;

    always #5 clk = ~clk;

    dr_tp_rx #(.WIDTH(32), .CNT_W(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .in      (tx_rails),
        .ack_o   (ack),
        .data_o  (data),
        .valid_o (valid),
        .ready_i (ready),
        .err_o   (err),
        .cnt_o   (cnt)
    );

    dr_tp_rx #(.WIDTH(8), .CNT_W(4)) dut_w (
        .clk     (clk),
        .rst     (rst),
        .in      (tx_s),
        .ack_o   (ack_s),
        .data_o  (data_s),
        .valid_o (valid_s),
        .ready_i (ready_s),
        .err_o   (err_s),
        .cnt_o   (cnt_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sender: toggle one rail per bit; bits set in 'both' toggle both rails.
    task automatic send_word(input logic [31:0] w, input logic [31:0] both);
        for (int b = 0; b < 32; b++) begin
            if (both[b])   tx_rails[b] = tx_rails[b] ^ 2'b11;
            else if (w[b]) tx_rails[b][1] = ~tx_rails[b][1];
            else           tx_rails[b][0] = ~tx_rails[b][0];
        end
    endtask

    // Send a word to an empty/draining slot, update the model and wait for ack.
    task automatic xfer(input logic [31:0] w, input logic [31:0] both, output logic timed_out);
        logic prev;
        prev = ack;
        send_word(w, both);
        exp_ack = ~exp_ack;
        exp_cnt = exp_cnt + 16'd1;
        if (both != 0) exp_err = 1'b1;
        for (int c = 0; c < 12 && ack === prev; c++) tick();
        timed_out = (ack === prev);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tx_rails = '0;
        tx_s = '0;
        ready = 1'b1;
        ready_s = 1'b1;
        tick();
        tick();
        checks++; if ({ack, valid, err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {ack, valid, err}); end
        checks++; if (data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h want 0", data); end
        checks++; if (cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
        checks++; if (cnt_s !== 4'd0 || valid_s !== 1'b0) begin errors++; $display("FAIL reset_small: cnt %0d valid %b want 0 0", cnt_s, valid_s); end
        rst = 1'b0;
        exp_ack = 1'b0;
        exp_cnt = 16'd0;
        exp_err = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_latency();
        send_word(32'h5, 32'h0);
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL lat_edge1_valid: got %b want 0", valid); end
        tick();
        checks++; if (valid !== 1'b0 || ack !== 1'b0) begin errors++; $display("FAIL lat_edge2: valid %b ack %b want 0 0", valid, ack); end
        tick();
        exp_ack = 1'b1;
        exp_cnt = 16'd1;
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL lat_edge3_valid: got %b want 1", valid); end
        checks++; if (data !== 32'h5) begin errors++; $display("FAIL lat_data: got %h want 00000005", data); end
        checks++; if (ack !== exp_ack || cnt !== exp_cnt) begin errors++; $display("FAIL lat_ack_cnt: ack %b cnt %0d want %b %0d", ack, cnt, exp_ack, exp_cnt); end
        $display("test_latency word 0x5 data=%h cnt=%0d", data, cnt);
        tick();
        tick();
    endtask

    task automatic test_skew();
        int order[32];
        logic [31:0] w;
        w = $urandom;
        for (int i = 0; i < 32; i++) order[i] = i;
        for (int i = 31; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(i, 0));
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        for (int i = 0; i < 32; i++) begin
            int b;
            b = order[i];
            if (w[b]) tx_rails[b][1] = ~tx_rails[b][1];
            else      tx_rails[b][0] = ~tx_rails[b][0];
            tick();
            checks++; if (valid !== 1'b0 || ack !== exp_ack) begin errors++; $display("FAIL skew_partial step %0d: valid %b ack %b want 0 %b", i, valid, ack, exp_ack); end
        end
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL skew_last_plus1: valid %b want 0", valid); end
        tick();
        exp_ack = ~exp_ack;
        exp_cnt = exp_cnt + 16'd1;
        checks++; if (valid !== 1'b1 || ack !== exp_ack) begin errors++; $display("FAIL skew_capture: valid %b ack %b want 1 %b", valid, ack, exp_ack); end
        checks++; if (data !== w) begin errors++; $display("FAIL skew_data: got %h want %h", data, w); end
        $display("test_skew word %h data=%h", w, data);
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] w1;
        logic [31:0] w2;
        logic        to;
        w1 = $urandom;
        w2 = ~w1;
        ready = 1'b0;
        xfer(w1, 32'h0, to);
        checks++; if (to || data !== w1 || valid !== 1'b1) begin errors++; $display("FAIL bp_word1: to %b data %h valid %b want 0 %h 1", to, data, valid, w1); end
        send_word(w2, 32'h0);
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++; if (ack !== exp_ack || data !== w1 || valid !== 1'b1) begin errors++; $display("FAIL bp_hold cyc %0d: ack %b data %h want %b %h", c, ack, data, exp_ack, w1); end
        end
        ready = 1'b1;
        tick();
        exp_ack = ~exp_ack;
        exp_cnt = exp_cnt + 16'd1;
        checks++; if (ack !== exp_ack || data !== w2 || valid !== 1'b1) begin errors++; $display("FAIL bp_release: ack %b data %h valid %b want %b %h 1", ack, data, valid, exp_ack, w2); end
        checks++; if (cnt !== exp_cnt) begin errors++; $display("FAIL bp_cnt: got %0d want %0d", cnt, exp_cnt); end
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL bp_drain: valid %b want 0", valid); end
        $display("test_backpressure w1 %h w2 %h data=%h", w1, w2, data);
    endtask

    task automatic test_fibonacci();
        logic [31:0] fib[$];
        int          toggles;
        logic        prev;
        logic        to;
        fib = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8};
        toggles = 0;
        foreach (fib[k]) begin
            prev = ack;
            xfer(fib[k], 32'h0, to);
            if (ack !== prev) toggles++;
            checks++; if (to || data !== fib[k] || cnt !== exp_cnt) begin errors++; $display("FAIL fib_word %0d: data %h cnt %0d want %h %0d", k, data, cnt, fib[k], exp_cnt); end
            $display("test_fibonacci word %0d data=%0d cnt=%0d", k, data, cnt);
        end
        checks++; if (toggles != 7) begin errors++; $display("FAIL fib_toggles: got %0d want 7", toggles); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL fib_err: got %b want 0", err); end
    endtask

    task automatic test_invalid();
        logic [31:0] w;
        logic        to;
        w = $urandom;
        xfer(w, 32'h80, to);
        checks++; if (to || data !== (w | 32'h80)) begin errors++; $display("FAIL inv_data: got %h want %h", data, w | 32'h80); end
        checks++; if (err !== exp_err) begin errors++; $display("FAIL inv_err: got %b want %b", err, exp_err); end
        $display("test_invalid word %h data=%h err=%b", w, data, err);
        for (int k = 0; k < 2; k++) begin
            w = $urandom;
            xfer(w, 32'h0, to);
            checks++; if (to || data !== w || err !== exp_err) begin errors++; $display("FAIL inv_sticky %0d: data %h err %b want %h %b", k, data, err, w, exp_err); end
        end
    endtask

    task automatic test_reset_mid_word();
        logic [31:0] w;
        logic        to;
        tick();
        tick();
        w = $urandom;
        for (int b = 0; b < 16; b++) begin
            if (w[b]) tx_rails[b][1] = ~tx_rails[b][1];
            else      tx_rails[b][0] = ~tx_rails[b][0];
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (valid !== 1'b0 || ack !== exp_ack) begin errors++; $display("FAIL mid_partial cyc %0d: valid %b ack %b want 0 %b", c, valid, ack, exp_ack); end
        end
        rst = 1'b1;
        tx_rails = '0;
        tick();
        checks++; if ({ack, valid, err} !== 3'b000 || data !== 32'd0 || cnt !== 16'd0) begin errors++; $display("FAIL mid_reset: ack %b valid %b err %b data %h cnt %0d want all 0", ack, valid, err, data, cnt); end
        rst = 1'b0;
        exp_ack = 1'b0;
        exp_cnt = 16'd0;
        exp_err = 1'b0;
        w = $urandom;
        xfer(w, 32'h0, to);
        checks++; if (to || data !== w || cnt !== 16'd1 || err !== 1'b0) begin errors++; $display("FAIL mid_after: data %h cnt %0d err %b want %h 1 0", data, cnt, err, w); end
        $display("test_reset_mid_word word %h data=%h cnt=%0d", w, data, cnt);
    endtask

    task automatic test_cnt_wrap();
        logic       s_ack;
        logic [3:0] s_cnt;
        logic [7:0] w;
        logic       prev;
        s_ack = 1'b0;
        s_cnt = 4'd0;
        for (int k = 0; k < 18; k++) begin
            w = 8'($urandom);
            prev = ack_s;
            for (int b = 0; b < 8; b++) begin
                if (w[b]) tx_s[b][1] = ~tx_s[b][1];
                else      tx_s[b][0] = ~tx_s[b][0];
            end
            for (int c = 0; c < 12 && ack_s === prev; c++) tick();
            s_ack = ~s_ack;
            s_cnt = s_cnt + 4'd1;
            checks++; if (ack_s !== s_ack || data_s !== w || cnt_s !== s_cnt) begin errors++; $display("FAIL wrap_word %0d: ack %b data %h cnt %0d want %b %h %0d", k, ack_s, data_s, cnt_s, s_ack, w, s_cnt); end
            $display("test_cnt_wrap word %0d data=%h cnt=%0d", k, data_s, cnt_s);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_skew();
        test_backpressure();
        test_fibonacci();
        test_invalid();
        test_reset_mid_word();
        test_cnt_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
